// File: rtl/axi_lite_slave_port_if.sv
// AXI4-Lite slave bundle plus the simple memory-side request/ack port behind it.
// Latency: none, this is wiring only.
// Backpressure: AXI channels use valid/ready; the memory side uses an en pulse and an ack.
// Ports: AW/W/B/AR/R channel signals (slave modport drives READY/B/R), and the
//        mem_wr_* / mem_rd_* request outputs with their ack/data inputs.
interface axi_lite_slave_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              AWVALID, AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              WVALID, WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID, BREADY;
  logic [1:0]        BRESP;
  logic              ARVALID, ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID, RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [STRB_W-1:0] mem_wr_strb;
  logic              mem_wr_ack;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_ack;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb,
    input  mem_wr_ack,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data, mem_rd_ack
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb,
    output mem_wr_ack,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data, mem_rd_ack
  );
endinterface

// File: rtl/axi_lite_slave_port.sv
// AXI4-Lite slave that turns single transactions into one-cycle memory requests.
// Latency: 3 cycles handshake-to-VALID with a memory acking the cycle after en.
// Backpressure: one outstanding op per direction; READY stays low until B/R is accepted.
// Ports: ACLK, ARESETn (synchronous, active-low), bus (axi_lite_slave_port_if.slave).
// Build option: define AXIL_DECERR_EN to answer addresses >= ADDR_LIMIT with DECERR
// locally (no memory access); otherwise everything is forwarded and ADDR_LIMIT is unused.
module axi_lite_slave_port #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0001_0000)
) (
  input logic                  ACLK,
  input logic                  ARESETn,
  axi_lite_slave_port_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_MEM, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_WAIT, R_RESP} r_state_t;

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  logic              aw_held, w_held;
  logic              aw_hs, w_hs, aw_have, w_have;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [1:0]        b_resp_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        r_resp_q;
  logic              w_decerr, r_decerr;

`ifdef AXIL_DECERR_EN
  // The write address may be arriving this very cycle or already be held.
  assign w_decerr = (aw_held ? aw_addr_q : bus.AWADDR) >= ADDR_LIMIT;
  assign r_decerr = bus.ARADDR >= ADDR_LIMIT;
`else
  assign w_decerr = 1'b0;
  assign r_decerr = 1'b0;
`endif

  // ---------------- write path ----------------
  always_comb begin
    w_next          = w_state;
    aw_hs           = 1'b0;
    w_hs            = 1'b0;
    aw_have         = aw_held;
    w_have          = w_held;
    bus.AWREADY     = 1'b0;
    bus.WREADY      = 1'b0;
    bus.BVALID      = 1'b0;
    bus.BRESP       = 2'b00;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_strb = '0;
    case (w_state)
      W_IDLE: begin
        bus.AWREADY = !aw_held;
        bus.WREADY  = !w_held;
        aw_hs       = bus.AWVALID && !aw_held;
        w_hs        = bus.WVALID && !w_held;
        aw_have     = aw_held || aw_hs;
        w_have      = w_held || w_hs;
        // Leave as soon as the second channel lands, whichever it is.
        if (aw_have && w_have) w_next = w_decerr ? W_RESP : W_MEM;
      end
      W_MEM: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = aw_addr_q;
        bus.mem_wr_data = w_data_q;
        bus.mem_wr_strb = w_strb_q;
        w_next          = bus.mem_wr_ack ? W_RESP : W_WAIT;
      end
      W_WAIT: begin
        bus.mem_wr_addr = aw_addr_q;
        bus.mem_wr_data = w_data_q;
        bus.mem_wr_strb = w_strb_q;
        if (bus.mem_wr_ack) w_next = W_RESP;
      end
      W_RESP: begin
        bus.BVALID = 1'b1;
        bus.BRESP  = b_resp_q;
        if (bus.BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= 2'b00;
    end else begin
      w_state <= w_next;
      // Held flags only live while collecting the two halves in idle.
      if (w_state == W_IDLE && w_next == W_IDLE) begin
        aw_held <= aw_have;
        w_held  <= w_have;
      end else begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (aw_hs) aw_addr_q <= bus.AWADDR;
      if (w_hs) begin
        w_data_q <= bus.WDATA;
        w_strb_q <= bus.WSTRB;
      end
      if (w_state == W_IDLE && w_next != W_IDLE) b_resp_q <= w_decerr ? 2'b11 : 2'b00;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    r_next          = r_state;
    bus.ARREADY     = 1'b0;
    bus.RVALID      = 1'b0;
    bus.RDATA       = '0;
    bus.RRESP       = 2'b00;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    case (r_state)
      R_IDLE: begin
        bus.ARREADY = 1'b1;
        if (bus.ARVALID) r_next = r_decerr ? R_RESP : R_MEM;
      end
      R_MEM: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = ar_addr_q;
        r_next          = bus.mem_rd_ack ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        bus.mem_rd_addr = ar_addr_q;
        if (bus.mem_rd_ack) r_next = R_RESP;
      end
      R_RESP: begin
        bus.RVALID = 1'b1;
        bus.RDATA  = rdata_q;
        bus.RRESP  = r_resp_q;
        if (bus.RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      r_resp_q  <= 2'b00;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && bus.ARVALID) begin
        ar_addr_q <= bus.ARADDR;
        r_resp_q  <= r_decerr ? 2'b11 : 2'b00;
        rdata_q   <= '0;  // stays zero for a locally answered error
      end
      if ((r_state == R_MEM || r_state == R_WAIT) && bus.mem_rd_ack) rdata_q <= bus.mem_rd_data;
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_port.sv
// Directed bench for axi_lite_slave_port: drives AXI-Lite stimulus, models the memory,
// and checks memory requests and B/R responses against queued expectations.
// Build with AXIL_DECERR_EN defined to exercise the out-of-range error responses.
module tb_axi_lite_slave_port;
  logic ACLK;
  logic ARESETn;

  axi_lite_slave_port_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  axi_lite_slave_port #(.ADDR_W(32), .DATA_W(64), .ADDR_LIMIT(32'h0001_0000)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] addr; logic [63:0] data; logic [7:0] strb; } wr_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; } r_t;

  wr_t         wq[$];
  logic [31:0] rdq[$];
  logic [1:0]  bq[$];
  r_t          rq[$];

  int          checks = 0;
  int          errors = 0;
  int          wr_dly = 1;
  int          rd_dly = 1;
  int          wr_cnt = -1;
  int          rd_cnt = -1;
  logic [63:0] rd_val = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents an output.
  initial begin : monitor
    wr_t we;
    r_t  re;
    forever begin
      @(negedge ACLK);
      if (bus.mem_wr_en) begin
        wr_cnt = wr_dly;
        if (wq.size() == 0) chk("unexpected_mem_wr_en", 64'd1, 64'd0);
        else begin
          we = wq.pop_front();
          chk("mem_wr_addr", 64'(bus.mem_wr_addr), 64'(we.addr));
          chk("mem_wr_data", bus.mem_wr_data, we.data);
          chk("mem_wr_strb", 64'(bus.mem_wr_strb), 64'(we.strb));
        end
      end
      if (bus.mem_rd_en) begin
        rd_cnt = rd_dly;
        if (rdq.size() == 0) chk("unexpected_mem_rd_en", 64'd1, 64'd0);
        else chk("mem_rd_addr", 64'(bus.mem_rd_addr), 64'(rdq.pop_front()));
      end
      if (bus.BVALID && bus.BREADY) begin
        if (bq.size() == 0) chk("unexpected_b", 64'd1, 64'd0);
        else chk("bresp", 64'(bus.BRESP), 64'(bq.pop_front()));
      end
      if (bus.RVALID && bus.RREADY) begin
        if (rq.size() == 0) chk("unexpected_r", 64'd1, 64'd0);
        else begin
          re = rq.pop_front();
          chk("rdata", bus.RDATA, re.data);
          chk("rresp", 64'(bus.RRESP), 64'(re.resp));
        end
      end
    end
  end

  // Memory model: acks a programmable number of cycles after each en pulse.
  initial begin : mem_model
    forever begin
      @(posedge ACLK); #1;
      bus.mem_wr_ack  = 1'b0;
      bus.mem_rd_ack  = 1'b0;
      bus.mem_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) bus.mem_wr_ack = 1'b1;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.mem_rd_ack  = 1'b1;
          bus.mem_rd_data = rd_val;
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    bit ok = 1'b0;
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge ACLK); ok = bus.AWREADY; end
    chk("aw_handshake", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit ok = 1'b0;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge ACLK); ok = bus.WREADY; end
    chk("w_handshake", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 1'b0;
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge ACLK); ok = bus.ARREADY; end
    chk("ar_handshake", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
  endtask

  // Counts negedges until the B handshake is visible.
  task automatic wait_b(output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin @(negedge ACLK); n++; seen = bus.BVALID && bus.BREADY; end
    chk("b_seen", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() + rdq.size() + bq.size() + rq.size()) != 0 && n < 200) begin
      @(negedge ACLK); n++;
    end
    chk("drain_pending", 64'(wq.size() + rdq.size() + bq.size() + rq.size()), 64'd0);
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_readys"}, 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);
    chk({tag, "_valids"}, 64'({bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}), 64'd0);
    chk({tag, "_rdata"}, bus.RDATA, 64'd0);
    chk({tag, "_mem_en"}, 64'({bus.mem_wr_en, bus.mem_rd_en}), 64'd0);
    chk({tag, "_mem_wr"}, 64'(bus.mem_wr_addr) | bus.mem_wr_data | 64'(bus.mem_wr_strb), 64'd0);
    chk({tag, "_mem_rd_addr"}, 64'(bus.mem_rd_addr), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n, nb, nr;
    bit          ok, bseen;
    logic [63:0] wd;
    bus.AWVALID = 0; bus.AWADDR = 0; bus.AWPROT = 0;
    bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.BREADY = 1;
    bus.ARVALID = 0; bus.ARADDR = 0; bus.ARPROT = 0; bus.RREADY = 1;
    bus.mem_wr_ack = 0; bus.mem_rd_ack = 0; bus.mem_rd_data = 0;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk_reset_vals("reset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK); #1;

    // AW first, W two cycles later, memory acks the cycle after en.
    wr_dly = 1;
    wq.push_back('{32'h10, 64'hDEAD_BEEF, 8'h0F});
    bq.push_back(2'b00);
    fork
      send_aw(32'h10);
      begin repeat (2) @(posedge ACLK); #1; send_w(64'hDEAD_BEEF, 8'h0F); end
    join
    wait_b(n);
    @(negedge ACLK);
    chk("ready_after_b", 64'({bus.AWREADY, bus.WREADY}), 64'b11);
    drain();

    // W before AW.
    wq.push_back('{32'h18, 64'h0123_4567_89AB_CDEF, 8'hF0});
    bq.push_back(2'b00);
    send_w(64'h0123_4567_89AB_CDEF, 8'hF0);
    @(negedge ACLK);
    chk("wready_low_after_w", 64'({bus.WREADY, bus.AWREADY}), 64'b01);
    @(posedge ACLK); #1;
    send_aw(32'h18);
    drain();

    // AW and W in the same cycle; also checks minimum write latency.
    wq.push_back('{32'h28, 64'hA5A5_0000_5A5A_FFFF, 8'hFF});
    bq.push_back(2'b00);
    fork
      send_aw(32'h28);
      send_w(64'hA5A5_0000_5A5A_FFFF, 8'hFF);
    join
    wait_b(n);
    chk("write_latency", 64'(n), 64'd3);
    drain();

    // Read with slow memory and a stalled master.
    rd_dly = 4; rd_val = 64'h1234; bus.RREADY = 1'b0;
    rdq.push_back(32'h20);
    rq.push_back('{64'h1234, 2'b00});
    send_ar(32'h20);
    ok = 1'b1; n = 0;
    while (!bus.RVALID && n < 50) begin @(negedge ACLK); n++; ok &= !bus.ARREADY; end
    chk("rvalid_seen", 64'(bus.RVALID), 64'd1);
    repeat (2) begin
      @(negedge ACLK);
      ok &= bus.RVALID && (bus.RDATA == 64'h1234) && (bus.RRESP == 2'b00) && !bus.ARREADY;
    end
    chk("r_stable_arready_low", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("arready_after_r", 64'(bus.ARREADY), 64'd1);
    drain();

    // Concurrent write and read; neither path may stall the other.
    wr_dly = 1; rd_dly = 1; rd_val = 64'hCAFE_F00D_0BAD_F00D;
    wq.push_back('{32'h30, 64'h1111_2222_3333_4444, 8'hFF});
    bq.push_back(2'b00);
    rdq.push_back(32'h40);
    rq.push_back('{64'hCAFE_F00D_0BAD_F00D, 2'b00});
    fork
      send_aw(32'h30);
      send_w(64'h1111_2222_3333_4444, 8'hFF);
      send_ar(32'h40);
    join
    nb = 0; nr = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge ACLK);
      if (bus.BVALID && nb == 0) nb = i;
      if (bus.RVALID && nr == 0) nr = i;
    end
    chk("conc_write_latency", 64'(nb), 64'd3);
    chk("conc_read_latency", 64'(nr), 64'd3);
    drain();

    // Out-of-range addresses.
    rd_val = 64'h55;
`ifdef AXIL_DECERR_EN
    bq.push_back(2'b11);
    rq.push_back('{64'h0, 2'b11});
`else
    wq.push_back('{32'h0002_0000, 64'h77, 8'h01});
    bq.push_back(2'b00);
    rdq.push_back(32'h0001_0000);
    rq.push_back('{64'h55, 2'b00});
`endif
    fork
      send_ar(32'h0001_0000);
      begin send_aw(32'h0002_0000); send_w(64'h77, 8'h01); end
    join
    drain();

    // Reset while waiting on memory; the late ack must not produce a response.
    wr_dly = 6;
    wd = 64'hFEED_FACE;
    wq.push_back('{32'h50, wd, 8'h3C});
    fork
      send_aw(32'h50);
      send_w(wd, 8'h3C);
    join
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin @(negedge ACLK); n++; ok = bus.mem_wr_en; end
    chk("rst_case_mem_wr_en", 64'(ok), 64'd1);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk_reset_vals("mid_reset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    bseen = 1'b0;
    repeat (12) begin @(negedge ACLK); bseen |= bus.BVALID; end
    chk("no_b_after_reset", 64'(bseen), 64'd0);
    chk("ready_after_reset", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);

    // Path still works after the abandoned transaction.
    wr_dly = 1;
    wq.push_back('{32'h60, 64'h600D, 8'h81});
    bq.push_back(2'b00);
    @(posedge ACLK); #1;
    fork
      send_aw(32'h60);
      send_w(64'h600D, 8'h81);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave_port.md
AXI_LITE_SLAVE_PORT -- requirements
Module: axi_lite_slave_port

Interface
REQ-001 Parameter ADDR_W, default 32, AXI and memory-side address width.
REQ-002 Parameter DATA_W, default 64, data width (32 or 64); STRB_W = DATA_W/8 is derived.
REQ-003 Parameter ADDR_LIMIT, default 32'h0001_0000, first invalid byte address (used only under REQ-030).
REQ-004 ACLK  in  1  clock; all logic is rising-edge.
REQ-005 ARESETn  in  1  reset, synchronous, active-low.
REQ-006 AWVALID/AWREADY  in/out  1  write address handshake; AWADDR in ADDR_W; AWPROT in 3 (ignored).
REQ-007 WVALID/WREADY  in/out  1  write data handshake; WDATA in DATA_W; WSTRB in STRB_W.
REQ-008 BVALID out 1, BREADY in 1, BRESP out 2  write response.
REQ-009 ARVALID/ARREADY  in/out  1  read address handshake; ARADDR in ADDR_W; ARPROT in 3 (ignored).
REQ-010 RVALID out 1, RREADY in 1, RDATA out DATA_W, RRESP out 2  read data.
REQ-011 mem_wr_en out 1, mem_wr_addr out ADDR_W, mem_wr_data out DATA_W, mem_wr_strb out STRB_W, mem_wr_ack in 1  memory write port.
REQ-012 mem_rd_en out 1, mem_rd_addr out ADDR_W, mem_rd_data in DATA_W, mem_rd_ack in 1  memory read port.

Function
REQ-013 The write and read paths are independent FSMs, each with at most one outstanding transaction.
REQ-014 Write FSM states: W_IDLE, W_MEM, W_WAIT, W_RESP.
REQ-015 In W_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured; AW and W may arrive in either order or in the same cycle.
REQ-016 Each captured channel drops its READY on the next cycle; the FSM enters W_MEM on the cycle after both are held.
REQ-017 W_MEM drives mem_wr_en=1 for exactly one cycle with the captured address, data and strobe; W_MEM -> W_WAIT.
REQ-018 mem_wr_addr/data/strb stay stable from W_MEM until mem_wr_ack.
REQ-019 mem_wr_ack is honoured in W_MEM or W_WAIT; on ack -> W_RESP with BVALID=1 and BRESP=2'b00 the next cycle.
REQ-020 BVALID and BRESP hold until BREADY; the cycle BVALID&&BREADY is seen -> W_IDLE, and AWREADY/WREADY reassert the following cycle.
REQ-021 Read FSM states: R_IDLE (ARREADY=1), R_MEM, R_WAIT, R_RESP.
REQ-022 ARVALID&&ARREADY captures ARADDR -> R_MEM; ARREADY=0 outside R_IDLE.
REQ-023 R_MEM drives mem_rd_en=1 for one cycle with the captured address; R_MEM -> R_WAIT.
REQ-024 mem_rd_ack is honoured in R_MEM or R_WAIT; mem_rd_data is latched on ack -> R_RESP with RVALID=1 and RRESP=2'b00.
REQ-025 RDATA and RRESP hold until RREADY; RVALID&&RREADY -> R_IDLE.
REQ-026 Minimum latency with zero-wait memory and a ready master: 3 cycles from address handshake to VALID, for both reads and writes.
REQ-027 Simultaneous read and write proceed concurrently with no mutual stall; memory-side ordering between the ports is not guaranteed.
REQ-028 Unencoded FSM states return to IDLE on the next cycle with all outputs deasserted.

Reset
REQ-029 When ARESETn=0 at a clock edge:
- both FSMs go to IDLE;
- AWREADY=WREADY=ARREADY=1;
- BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0;
- all mem_* outputs are 0.
Reset mid-transaction abandons the transaction without a response; a late mem_*_ack is ignored.

Configuration
REQ-030 With AXIL_DECERR_EN defined, an address >= ADDR_LIMIT skips MEM/WAIT:
- it goes directly to RESP with BRESP or RRESP=2'b11;
- RDATA=0;
- no mem_*_en pulse is issued.
Without the macro, all addresses are forwarded to memory, the response is always 2'b00, and ADDR_LIMIT is unused.

Verification
REQ-031 AW 0x10 then W 0xDEAD_BEEF/STRB 0x0F two cycles later, mem_wr_ack the cycle after mem_wr_en, BREADY=1 -> one mem_wr_en pulse at 0x10 with that data/strb; BVALID with BRESP=00; AWREADY/WREADY high again after B.
REQ-032 W before AW; AW and W in the same cycle -> identical single memory write each time.
REQ-033 AR 0x20, mem_rd_ack after 4 cycles with data 0x1234, RREADY held low 3 cycles -> RVALID/RDATA=0x1234 stable until RREADY; ARREADY low throughout.
REQ-034 Concurrent write to 0x30 and read from 0x40 -> both complete independently with correct B and R.
REQ-035 With AXIL_DECERR_EN, read 0x0001_0000 and write 0x0002_0000 -> RRESP=BRESP=11, no mem_*_en; without the macro, both are forwarded with response 00.
REQ-036 ARESETn low while in W_WAIT, followed by a late mem_wr_ack -> no BVALID, all reset values per REQ-029.
